// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bit counter width; only needs to reach WIDTH-1.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B, LSB first, with start/busy/done handshake.
// Optional signed-overflow output V enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  output logic             V,
`endif
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = cnt_w(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              brw_q, brw_d;
  logic              bout_q, bout_d;
  logic              diff_bit, brw_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic              a_msb_q, a_msb_d;
  logic              b_msb_q, b_msb_d;
  logic              v_q, v_d;
`endif

  full_subtractor u_full_sub (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (brw_q),
    .d    (diff_bit),
    .bout (brw_nxt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    v_d     = v_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          a_d     = A;
          b_d     = B;
          res_d   = '0;
          cnt_d   = '0;
          brw_d   = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        res_d = {diff_bit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = brw_nxt;
        cnt_d = cnt_q + CntW'(1);
        // Outputs only move on the completing edge, never mid-operation.
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          d_d     = {diff_bit, res_q[WIDTH-1:1]};
          bout_d  = brw_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          v_d     = (a_msb_q != b_msb_q) && (diff_bit != a_msb_q);
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      v_q     <= v_d;
`endif
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign V    = v_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): vector table plus handshake corner cases.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B, D;
  logic         Bout, busy, done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         V;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .D     (D),
    .Bout  (Bout),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    .V     (V),
`endif
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bout;
    logic         v;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one operation and follow it to completion; inputs change at negedge.
  task automatic run_op(input vec_t v);
    int n;
    logic [W-1:0] held_d;
    logic         held_b;
    held_d = D;
    held_b = Bout;
    @(negedge clk);
    A = v.a; B = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      if (D !== held_d || Bout !== held_b) begin
        check("partial_result_hidden", {27'd0, Bout, D}, {27'd0, held_b, held_d});
      end
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, W);
    check("done_pulse", done, 1'b1);
    check($sformatf("D_%0d_minus_%0d", v.a, v.b), D, v.d);
    check($sformatf("Bout_%0d_minus_%0d", v.a, v.b), Bout, v.bout);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check($sformatf("V_%0d_minus_%0d", v.a, v.b), V, v.v);
`endif
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    int cyc, t1, t2, ndone, n;
    logic [W-1:0] d1, d2;
    logic         b1, b2;

    vecs[0] = '{a: 4'd9,  b: 4'd2,  d: 4'd7,  bout: 1'b0, v: 1'b1};
    vecs[1] = '{a: 4'd0,  b: 4'd5,  d: 4'd11, bout: 1'b1, v: 1'b0};
    vecs[2] = '{a: 4'd15, b: 4'd15, d: 4'd0,  bout: 1'b0, v: 1'b0};
    vecs[3] = '{a: 4'd0,  b: 4'd15, d: 4'd1,  bout: 1'b1, v: 1'b0};
    vecs[4] = '{a: 4'd7,  b: 4'd8,  d: 4'd15, bout: 1'b1, v: 1'b1};
    vecs[5] = '{a: 4'd5,  b: 4'd3,  d: 4'd2,  bout: 1'b0, v: 1'b0};
    vecs[6] = '{a: 4'd12, b: 4'd1,  d: 4'd11, bout: 1'b0, v: 1'b0};
    vecs[7] = '{a: 4'd6,  b: 4'd9,  d: 4'd13, bout: 1'b1, v: 1'b1};
    vecs[8] = '{a: 4'd8,  b: 4'd8,  d: 4'd0,  bout: 1'b0, v: 1'b0};
    vecs[9] = '{a: 4'd14, b: 4'd7,  d: 4'd7,  bout: 1'b0, v: 1'b1};

    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_D", D, 0);
    check("reset_Bout", Bout, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("reset_V", V, 0);
`endif

    foreach (vecs[i]) run_op(vecs[i]);

    // Back-to-back: start held through DONE, second operands presented during first DONE.
    @(negedge clk);
    A = 4'd10; B = 4'd3; start = 1'b1;
    cyc = 0; ndone = 0; t1 = 0; t2 = 0;
    d1 = '0; d2 = '0; b1 = 1'b0; b2 = 1'b0;
    while (ndone < 2 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          t1 = cyc; d1 = D; b1 = Bout;
          A = 4'd3; B = 4'd10;
        end else begin
          t2 = cyc; d2 = D; b2 = Bout;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_done_count", ndone, 2);
    check("b2b_first_D", d1, 7);
    check("b2b_first_Bout", b1, 0);
    check("b2b_second_D", d2, 9);
    check("b2b_second_Bout", b2, 1);
    check("b2b_spacing", t2 - t1, W + 1);
    @(negedge clk);
    check("b2b_back_idle", {busy, done}, 2'b00);

    // start and operands changed mid-RUN must be ignored.
    @(negedge clk);
    A = 4'd3; B = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 4'd15; B = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midrun_done_seen", done, 1'b1);
    check("midrun_D", D, 15);
    check("midrun_Bout", Bout, 1);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("midrun_no_extra_op", ndone, 0);

    // Reset on the second RUN cycle aborts without a done pulse.
    @(negedge clk);
    A = 4'd12; B = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_first", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_D", D, 0);
    check("abort_Bout", Bout, 0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("abort_no_done", ndone, 0);

    // Reset beats start on the same edge.
    @(negedge clk);
    A = 4'd9; B = 4'd1; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_priority_busy", busy, 0);
    check("rst_priority_D", D, 0);

    // Normal operation after the abort.
    run_op(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
